// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared Q-format helpers and divider state encoding
//
// Purpose: common types and constants for the fixed-point datapath units
//          (fpdu divider, FPMU multiplier).
// Contents:
//   fpdu_state_t  - divider FSM states
//   fp_max_pos()  - largest representable result pattern for SIGN/WIDTH
//   fp_min_neg()  - most negative result pattern (also its magnitude)

package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } fpdu_state_t;

    // Unsigned: all ones. Signed: 0111..1.
    function automatic logic [63:0] fp_max_pos(input int sign, input int width);
        if (sign != 0) begin
            return (64'd1 << (width - 1)) - 64'd1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    // 1000..0: the min-negative bit pattern, equal to its own magnitude.
    function automatic logic [63:0] fp_min_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fpdu_if.sv
// rtl/fpdu_if.sv - operand/result handshake bundle for the fixed-point divider
//
// Purpose: groups the request (in_*, a, b) and response (out_*, result,
//          ovf, dbz) channels of fpdu.
// Modports:
//   master - producer/consumer side: drives in_valid, a, b, out_ready
//   slave  - divider side: drives in_ready, out_valid, result, ovf, dbz

interface fpdu_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             dbz;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, dbz
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, ovf, dbz
    );

endinterface

// File: rtl/fp_restore_step.sv
// rtl/fp_restore_step.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit into the partial remainder and
//          subtracts the divisor when it fits.
// Ports:
//   i_rem [WIDTH:0]   partial remainder (always < divisor on entry)
//   i_bit             next dividend bit, MSB first
//   i_div [WIDTH-1:0] divisor magnitude
//   o_rem [WIDTH:0]   updated remainder
//   o_q               quotient bit produced by this step

module fp_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;

    // Compare at full width so the shifted-out remainder MSB is never lost.
    assign w_shift = {i_rem, i_bit};
    assign o_q     = (w_shift >= {2'b00, i_div});
    // When the divisor fits, the difference is below 2^(WIDTH+1), so the
    // low WIDTH+1 bits of the subtraction are exact.
    assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_div};
    assign o_rem   = o_q ? w_diff : w_shift[WIDTH:0];

endmodule

// File: rtl/fpdu.sv
// rtl/fpdu.sv - sequential fixed-point divider, result = (a << FP_POSITIONS) / b
//
// Purpose: iterative restoring divider, one quotient bit per cycle, with
//          truncation toward zero, saturation (ovf) and divide-by-zero (dbz).
// Parameters:
//   SIGN         0 unsigned, 1 two's-complement
//   WIDTH        operand/result width
//   FP_POSITIONS fractional bits (< WIDTH)
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fpdu_if.slave: in_valid/in_ready/a/b, out_valid/out_ready/result/ovf/dbz

module fpdu
    import fp_pkg::*;
#(
    parameter int SIGN         = 0,
    parameter int WIDTH        = 8,
    parameter int FP_POSITIONS = 4
) (
    input  logic  clk,
    input  logic  rst,
    fpdu_if.slave bus
);

    localparam int N  = WIDTH + FP_POSITIONS;
    localparam int CW = $clog2(N + 1);

    localparam logic [WIDTH-1:0] MAX_POS   = WIDTH'(fp_max_pos(SIGN, WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG   = WIDTH'(fp_min_neg(WIDTH));
    localparam logic [N-1:0]     Q_MAX_POS = N'(fp_max_pos(SIGN, WIDTH));
    localparam logic [N-1:0]     Q_MIN_MAG = N'(fp_min_neg(WIDTH));

    fpdu_state_t r_state;
    fpdu_state_t w_state_next;

    logic [N-1:0]     r_dividend;
    logic [WIDTH:0]   r_rem;
    logic [N-1:0]     r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_neg;
    logic             r_a_neg;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_dbz;

    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_a_neg;
    logic             w_neg;
    logic             w_b_zero;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_q;
    logic [WIDTH-1:0] w_fix_result;
    logic             w_fix_ovf;

    // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
    assign w_a_neg  = (SIGN != 0) && bus.a[WIDTH-1];
    assign w_a_abs  = w_a_neg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    assign w_b_abs  = ((SIGN != 0) && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    assign w_neg    = (SIGN != 0) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    assign w_b_zero = (bus.b == {WIDTH{1'b0}});

    fp_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_dividend[N-1]),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A zero divisor still passes through FIX so the
    // dbz result is registered the same way as a normal quotient.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = w_b_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
    end

    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.dbz    = r_dbz;

    // Sign fix and saturation of the unsigned quotient magnitude.
    always_comb begin
        w_fix_result = r_q[WIDTH-1:0];
        w_fix_ovf    = 1'b0;
        if (r_zero) begin
            w_fix_result = r_a_neg ? MIN_NEG : MAX_POS;
        end else if (r_neg) begin
            if (r_q > Q_MIN_MAG) begin
                w_fix_result = MIN_NEG;
                w_fix_ovf    = 1'b1;
            end else begin
                w_fix_result = {WIDTH{1'b0}} - r_q[WIDTH-1:0];
            end
        end else if (r_q > Q_MAX_POS) begin
            w_fix_result = MAX_POS;
            w_fix_ovf    = 1'b1;
        end
    end

    // Datapath: operand latch, shift/subtract iterations, result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_div      <= '0;
            r_neg      <= 1'b0;
            r_a_neg    <= 1'b0;
            r_zero     <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_dividend <= N'(w_a_abs) << FP_POSITIONS;
                        r_rem      <= '0;
                        r_q        <= '0;
                        r_div      <= w_b_abs;
                        r_neg      <= w_neg;
                        r_a_neg    <= w_a_neg;
                        r_zero     <= w_b_zero;
                        r_cnt      <= CW'(N);
                    end
                end
                CALC: begin
                    r_dividend <= r_dividend << 1;
                    r_rem      <= w_step_rem;
                    r_q        <= {r_q[N-2:0], w_step_q};
                    r_cnt      <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_result <= w_fix_result;
                    r_ovf    <= w_fix_ovf;
                    r_dbz    <= r_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpdu.sv
// tb/tb_fpdu.sv - self-checking bench for fpdu, unsigned and signed instances

module tb_fpdu;

    typedef struct {
        bit         sgn;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    fpdu_if #(.WIDTH(8)) if0 ();
    fpdu_if #(.WIDTH(8)) if1 ();

    fpdu #(.SIGN(0), .WIDTH(8), .FP_POSITIONS(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
    fpdu #(.SIGN(1), .WIDTH(8), .FP_POSITIONS(4)) u1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive_in(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            if1.in_valid = v; if1.a = a; if1.b = b;
        end else begin
            if0.in_valid = v; if0.a = a; if0.b = b;
        end
    endtask

    task automatic set_ordy(input bit sel, input logic v);
        if (sel) if1.out_ready = v;
        else     if0.out_ready = v;
    endtask

    function automatic logic f_in_ready(input bit sel);
        return sel ? if1.in_ready : if0.in_ready;
    endfunction
    function automatic logic f_out_valid(input bit sel);
        return sel ? if1.out_valid : if0.out_valid;
    endfunction
    function automatic logic [7:0] f_result(input bit sel);
        return sel ? if1.result : if0.result;
    endfunction
    function automatic logic f_ovf(input bit sel);
        return sel ? if1.ovf : if0.ovf;
    endfunction
    function automatic logic f_dbz(input bit sel);
        return sel ? if1.dbz : if0.dbz;
    endfunction

    // Behavioural reference: integer divide (truncates toward zero) then clamp.
    function automatic exp_t model(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   q, na, nb;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        e.r   = 8'h00;
        if (b == 8'h00) begin
            e.dbz = 1'b1;
            e.r   = (sgn && a[7]) ? 8'h80 : (sgn ? 8'h7F : 8'hFF);
        end else if (!sgn) begin
            na = a;
            nb = b;
            q  = (na * 16) / nb;
            if (q > 255) begin e.r = 8'hFF; e.ovf = 1'b1; end
            else e.r = q[7:0];
        end else begin
            na = $signed(a);
            nb = $signed(b);
            q  = (na * 16) / nb;
            if (q > 127)       begin e.r = 8'h7F; e.ovf = 1'b1; end
            else if (q < -128) begin e.r = 8'h80; e.ovf = 1'b1; end
            else e.r = q[7:0];
        end
        return e;
    endfunction

    function automatic vec_t mk(input bit s, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic o, input logic d, input int lat);
        vec_t v;
        v.sgn = s; v.a = a; v.b = b; v.r = r; v.ovf = o; v.dbz = d; v.lat = lat;
        return v;
    endfunction

    // One complete transaction: request, wait for result, optional stall, release.
    task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input exp_t e,
                         input int stall, input bit poke, input int want_lat);
        int   k;
        exp_t x;
        @(negedge clk);
        drive_in(sel, 1'b1, a, b);
        k = 0;
        while (!f_in_ready(sel) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!f_in_ready(sel)) begin
            chk("accept_timeout", 0, 1);
            drive_in(sel, 1'b0, a, b);
            return;
        end
        sb.push_back(e);
        @(negedge clk);
        // Operands change after the accept edge; they must have no effect.
        drive_in(sel, 1'b0, ~a, ~b);
        k = 0;
        while (!f_out_valid(sel) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!f_out_valid(sel)) begin
            chk("result_timeout", 0, 1);
            if (sb.size() > 0) x = sb.pop_front();
            return;
        end
        chk("latency", k, want_lat);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        x = sb.pop_front();
        chk("result", f_result(sel), x.r);
        chk("ovf", f_ovf(sel), x.ovf);
        chk("dbz", f_dbz(sel), x.dbz);
        for (int i = 0; i < stall; i++) begin
            if (poke) drive_in(sel, 1'b1, 8'h33, 8'h01);
            @(negedge clk);
            chk("hold_valid", f_out_valid(sel), 1);
            chk("hold_result", {f_result(sel), f_ovf(sel), f_dbz(sel)}, {x.r, x.ovf, x.dbz});
            chk("hold_in_ready", f_in_ready(sel), 0);
        end
        drive_in(sel, 1'b0, 8'h00, 8'h00);
        set_ordy(sel, 1'b1);
        @(negedge clk);
        set_ordy(sel, 1'b0);
        chk("released_valid", f_out_valid(sel), 0);
        chk("released_in_ready", f_in_ready(sel), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [7:0] ra, rb;
        bit   saw_valid;
        int   s;

        tbl[0]  = mk(0, 8'h14, 8'h10, 8'h14, 0, 0, 13);
        tbl[1]  = mk(0, 8'h10, 8'h08, 8'h20, 0, 0, 13);
        tbl[2]  = mk(0, 8'hFF, 8'h01, 8'hFF, 1, 0, 13);
        tbl[3]  = mk(0, 8'h10, 8'h00, 8'hFF, 0, 1, 1);
        tbl[4]  = mk(1, 8'hF0, 8'h00, 8'h80, 0, 1, 1);
        tbl[5]  = mk(1, 8'hF0, 8'h14, 8'hF4, 0, 0, 13);
        tbl[6]  = mk(1, 8'h80, 8'hFF, 8'h7F, 1, 0, 13);
        tbl[7]  = mk(0, 8'h0F, 8'h01, 8'hF0, 0, 0, 13);
        tbl[8]  = mk(0, 8'h10, 8'h01, 8'hFF, 1, 0, 13);
        tbl[9]  = mk(1, 8'h07, 8'h01, 8'h70, 0, 0, 13);
        tbl[10] = mk(1, 8'h08, 8'h01, 8'h7F, 1, 0, 13);
        tbl[11] = mk(1, 8'hF8, 8'h01, 8'h80, 0, 0, 13);
        tbl[12] = mk(1, 8'hF7, 8'h01, 8'h80, 1, 0, 13);
        tbl[13] = mk(1, 8'h08, 8'hF0, 8'hF8, 0, 0, 13);
        tbl[14] = mk(1, 8'h00, 8'h00, 8'h7F, 0, 1, 1);
        tbl[15] = mk(0, 8'h00, 8'h05, 8'h00, 0, 0, 13);

        drive_in(0, 1'b0, 8'h00, 8'h00);
        drive_in(1, 1'b0, 8'h00, 8'h00);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", f_in_ready(d[0]), 1);
            chk("reset_out_valid", f_out_valid(d[0]), 0);
            chk("reset_outputs", {f_result(d[0]), f_ovf(d[0]), f_dbz(d[0])}, 10'h000);
        end

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            e.r = tbl[i].r; e.ovf = tbl[i].ovf; e.dbz = tbl[i].dbz;
            do_op(tbl[i].sgn, tbl[i].a, tbl[i].b, e, 0, 0, tbl[i].lat);
        end

        // Backpressure: 20 stalled cycles with new requests being offered
        do_op(0, 8'h14, 8'h10, model(0, 8'h14, 8'h10), 20, 1, 13);
        do_op(1, 8'h80, 8'hFF, model(1, 8'h80, 8'hFF), 20, 1, 13);

        // Reset in the middle of CALC
        do_op(0, 8'hFF, 8'h01, model(0, 8'hFF, 8'h01), 0, 0, 13);
        @(negedge clk);
        drive_in(0, 1'b1, 8'h30, 8'h02);
        @(negedge clk);
        drive_in(0, 1'b0, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        chk("mid_calc_busy", f_in_ready(0), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", f_in_ready(0), 1);
        chk("async_rst_out_valid", f_out_valid(0), 0);
        chk("async_rst_outputs", {f_result(0), f_ovf(0), f_dbz(0)}, 10'h000);
        @(negedge clk);
        rst = 1'b0;
        set_ordy(0, 1'b1);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.out_valid) saw_valid = 1'b1;
        end
        set_ordy(0, 1'b0);
        chk("no_stale_valid", saw_valid, 0);
        do_op(0, 8'h30, 8'h02, model(0, 8'h30, 8'h02), 0, 0, 13);

        // Random compare, both signedness modes, random output stalls
        for (int sg = 0; sg < 2; sg++) begin
            for (int i = 0; i < 200; i++) begin
                ra = 8'($urandom);
                rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
                s  = $urandom_range(0, 3);
                do_op(sg[0], ra, rb, model(sg[0], ra, rb), s, 0, (rb == 8'h00) ? 1 : 13);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
